spi_mem_arbiter: RTL and testbench

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/manquehuito_pkg.sv | 26 ++
 rtl/spi_mem_arbiter_if.sv | 25 ++
 rtl/spi_req_picker.sv | 44 ++++
 rtl/spi_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/manquehuito_pkg.sv
// Shared types and constants for the SPI memory arbiter: FSM states, requester IDs,
// SPI byte-count codes and bus widths.
package manquehuito_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam logic [1:0] NB_ONE = 2'b01;
  localparam logic [1:0] NB_TWO = 2'b10;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 15;
  localparam int unsigned NB_W    = 2;
  localparam int unsigned BURST_W = 3;

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// SPI master command/response bus; master = arbiter side, slave = SPI engine side.
interface spi_mem_arbiter_if;
  import manquehuito_pkg::*;

  logic              spi_start_o;
  logic [ADDR_W-1:0] spi_address_o;
  logic [DATA_W-1:0] spi_data_write_o;
  logic              spi_read_not_write_o;
  logic [NB_W-1:0]   spi_num_bytes_o;
  logic [DATA_W-1:0] spi_byte1_i;
  logic [DATA_W-1:0] spi_byte2_i;
  logic              spi_done_i;
  logic              spi_busy_i;

  modport master (
    output spi_start_o, spi_address_o, spi_data_write_o, spi_read_not_write_o, spi_num_bytes_o,
    input  spi_byte1_i, spi_byte2_i, spi_done_i, spi_busy_i
  );

  modport slave (
    input  spi_start_o, spi_address_o, spi_data_write_o, spi_read_not_write_o, spi_num_bytes_o,
    output spi_byte1_i, spi_byte2_i, spi_done_i, spi_busy_i
  );

endinterface

// File: rtl/spi_req_picker.sv
// Fetch/data requester select: data has priority, but a pending fetch wins once
// MAX_DATA_BURST consecutive data grants have been issued.
module spi_req_picker
  import manquehuito_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  input  logic    en_i,
  input  logic    if_req_i,
  input  logic    d_req_i,
  output logic    pick_valid_o,
  output req_id_e pick_id_o
);

  logic [BURST_W-1:0] burst_q, burst_d;
  logic               fetch_wins;

  assign fetch_wins = if_req_i && (!d_req_i || (burst_q == BURST_W'(MAX_DATA_BURST)));

  // Select and saturating burst-count update; counter only moves on an actual grant.
  always_comb begin
    pick_valid_o = en_i && (if_req_i || d_req_i);
    pick_id_o    = fetch_wins ? REQ_FETCH : REQ_DATA;
    burst_d      = burst_q;
    if (pick_valid_o) begin
      if (fetch_wins || !if_req_i) begin
        burst_d = '0;
      end else if (burst_q != '1) begin
        burst_d = burst_q + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory master between an instruction-fetch port and a data port,
// with a per-transaction timeout and sticky error flag.
module spi_mem_arbiter
  import manquehuito_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_core_i,
  input  logic               rst_n_i,
  input  logic               if_req_i,
  input  logic [ADDR_W-1:0]  if_addr_i,
  output logic               if_gnt_o,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  input  logic               d_req_i,
  input  logic               d_we_i,
  input  logic [ADDR_W-1:0]  d_addr_i,
  input  logic [DATA_W-1:0]  d_wdata_i,
  output logic               d_gnt_o,
  output logic               d_valid_o,
  output logic [DATA_W-1:0]  d_rdata_o,
  spi_mem_arbiter_if.master  spi,
  output logic               err_o,
  output logic               busy_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q;
  req_id_e            served_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               rnw_q;
  logic [NB_W-1:0]    nb_q;
  logic               start_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               if_valid_q, d_valid_q;
  logic               err_q;
  logic [TMO_W-1:0]   tmo_q;

  logic    grant_en;
  logic    pick_valid;
  req_id_e pick_id;
  logic    timeout;
  logic    unused_byte2_msb;

  // Grants are gated by reset so every output reads 0 while rst_n_i is low.
  assign grant_en         = (state_q == ST_IDLE) && rst_n_i;
  assign timeout          = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign unused_byte2_msb = spi.spi_byte2_i[7];

  spi_req_picker #(
    .MAX_DATA_BURST (MAX_DATA_BURST)
  ) u_picker (
    .clk_i        (clk_core_i),
    .rst_n_i      (rst_n_i),
    .en_i         (grant_en),
    .if_req_i     (if_req_i),
    .d_req_i      (d_req_i),
    .pick_valid_o (pick_valid),
    .pick_id_o    (pick_id)
  );

  assign if_gnt_o = pick_valid && (pick_id == REQ_FETCH);
  assign d_gnt_o  = pick_valid && (pick_id == REQ_DATA);
  assign busy_o   = (state_q != ST_IDLE);

  assign if_valid_o               = if_valid_q;
  assign if_instr_o               = instr_q;
  assign d_valid_o                = d_valid_q;
  assign d_rdata_o                = rdata_q;
  assign err_o                    = err_q;
  assign spi.spi_start_o          = start_q;
  assign spi.spi_address_o        = addr_q;
  assign spi.spi_data_write_o     = wdata_q;
  assign spi.spi_read_not_write_o = rnw_q;
  assign spi.spi_num_bytes_o      = nb_q;

  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      served_q   <= REQ_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      rnw_q      <= 1'b0;
      nb_q       <= '0;
      start_q    <= 1'b0;
      instr_q    <= '0;
      rdata_q    <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            served_q <= pick_id;
            tmo_q    <= '0;
            start_q  <= 1'b1;
            state_q  <= ST_START;
            if (pick_id == REQ_FETCH) begin
              addr_q <= if_addr_i;
              rnw_q  <= 1'b1;
              nb_q   <= NB_TWO;
            end else begin
              addr_q  <= d_addr_i;
              rnw_q   <= !d_we_i;
              nb_q    <= NB_ONE;
              wdata_q <= d_wdata_i;
            end
          end
        end
        ST_START, ST_WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          // Done beats a coincident timeout and leaves err untouched.
          if ((state_q == ST_WAIT) && spi.spi_done_i) begin
            state_q <= ST_RESP;
            if (served_q == REQ_FETCH) begin
              instr_q    <= {spi.spi_byte1_i, spi.spi_byte2_i[6:0]};
              if_valid_q <= 1'b1;
            end else begin
              if (rnw_q) rdata_q <= spi.spi_byte1_i;
              d_valid_q <= 1'b1;
            end
          end else if (timeout) begin
            state_q <= ST_RESP;
            start_q <= 1'b0;
            err_q   <= 1'b1;
            if (served_q == REQ_FETCH) begin
              instr_q    <= '0;
              if_valid_q <= 1'b1;
            end else begin
              rdata_q   <= '0;
              d_valid_q <= 1'b1;
            end
          end else if ((state_q == ST_START) && spi.spi_busy_i) begin
            state_q <= ST_WAIT;
            start_q <= 1'b0;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter against a small SPI master model.
module tb_spi_mem_arbiter;
  import manquehuito_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_req_i;
  logic [15:0] if_addr_i;
  logic        if_gnt_o, if_valid_o;
  logic [14:0] if_instr_o;
  logic        d_req_i, d_we_i;
  logic [15:0] d_addr_i;
  logic [7:0]  d_wdata_i;
  logic        d_gnt_o, d_valid_o;
  logic [7:0]  d_rdata_o;
  logic        err_o, busy_o;

  int checks   = 0;
  int failures = 0;

  // SPI master model controls and observations
  logic        model_en;
  int          model_lat;
  int          m_cnt;
  logic [7:0]  m_byte1, m_byte2;
  logic [1:0]  obs_nb;
  logic        obs_rnw;
  logic [15:0] obs_addr;
  logic [7:0]  obs_wdata;

  spi_mem_arbiter_if u_spi ();

  assign u_spi.spi_byte1_i = m_byte1;
  assign u_spi.spi_byte2_i = m_byte2;

  spi_mem_arbiter #(
    .MAX_DATA_BURST (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk_core_i (clk),
    .rst_n_i    (rst_n),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_valid_o (if_valid_o),
    .if_instr_o (if_instr_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_valid_o  (d_valid_o),
    .d_rdata_o  (d_rdata_o),
    .spi        (u_spi),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI master model: accepts start, raises busy, then pulses done after model_lat cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_spi.spi_busy_i <= 1'b0;
      u_spi.spi_done_i <= 1'b0;
      m_cnt            <= 0;
    end else begin
      u_spi.spi_done_i <= 1'b0;
      if (u_spi.spi_busy_i) begin
        if (m_cnt == 0) begin
          u_spi.spi_done_i <= 1'b1;
          u_spi.spi_busy_i <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (model_en && u_spi.spi_start_o && !u_spi.spi_done_i) begin
        u_spi.spi_busy_i <= 1'b1;
        m_cnt            <= model_lat;
        obs_nb           <= u_spi.spi_num_bytes_o;
        obs_rnw          <= u_spi.spi_read_not_write_o;
        obs_addr         <= u_spi.spi_address_o;
        obs_wdata        <= u_spi.spi_data_write_o;
      end
    end
  end

  task automatic wait_valid(input bit fetch, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(posedge clk); #1;
      n++;
      if (fetch ? if_valid_o : d_valid_o) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
    model_en = 1; model_lat = 0; m_byte1 = '0; m_byte2 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt_o, if_valid_o, if_instr_o, d_gnt_o, d_valid_o, d_rdata_o, err_o, busy_o,
         u_spi.spi_start_o, u_spi.spi_address_o, u_spi.spi_num_bytes_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got instr=%h rdata=%h err=%b busy=%b start=%b",
               if_instr_o, d_rdata_o, err_o, busy_o, u_spi.spi_start_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle: busy_o got=%b exp=0", busy_o);
    end
  endtask

  task automatic test_fetch();
    int n;
    m_byte1 = 8'hA5; m_byte2 = 8'hC3; model_lat = 0;
    if_addr_i = 16'h0012; if_req_i = 1;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin
      failures++; $display("FAIL fetch_gnt: if_gnt=%b d_gnt=%b exp 1/0", if_gnt_o, d_gnt_o);
    end
    wait_valid(1'b1, 50, n);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL fetch_latency: got=%0d exp=4", n);
    end
    checks++;
    if (if_instr_o !== 15'h52C3) begin
      failures++; $display("FAIL fetch_instr: got=%h exp=52c3", if_instr_o);
    end
    checks++;
    if (if_gnt_o !== 1'b0 || d_valid_o !== 1'b0) begin
      failures++; $display("FAIL fetch_resp_gnt: if_gnt=%b d_valid=%b exp 0/0", if_gnt_o, d_valid_o);
    end
    checks++;
    if (obs_nb !== 2'b10 || obs_rnw !== 1'b1 || obs_addr !== 16'h0012) begin
      failures++; $display("FAIL fetch_cmd: nb=%b rnw=%b addr=%h exp 10/1/0012", obs_nb, obs_rnw, obs_addr);
    end
    if_req_i = 0;
    @(posedge clk); #1;
    checks++;
    if (if_valid_o !== 1'b0 || busy_o !== 1'b0 || if_instr_o !== 15'h52C3) begin
      failures++;
      $display("FAIL fetch_pulse: valid=%b busy=%b instr=%h exp 0/0/52c3", if_valid_o, busy_o, if_instr_o);
    end
  endtask

  task automatic test_load_store();
    int n;
    m_byte1 = 8'h7E; m_byte2 = 8'h00;
    d_addr_i = 16'h0040; d_we_i = 0; d_req_i = 1;
    #1;
    checks++;
    if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      failures++; $display("FAIL load_gnt: d_gnt=%b if_gnt=%b exp 1/0", d_gnt_o, if_gnt_o);
    end
    @(posedge clk); #1 d_req_i = 0;
    wait_valid(1'b0, 50, n);
    checks++;
    if (n < 0 || d_rdata_o !== 8'h7E) begin
      failures++; $display("FAIL load_rdata: got=%h seen=%0d exp=7e", d_rdata_o, n);
    end
    checks++;
    if (obs_nb !== 2'b01 || obs_rnw !== 1'b1 || obs_addr !== 16'h0040) begin
      failures++; $display("FAIL load_cmd: nb=%b rnw=%b addr=%h exp 01/1/0040", obs_nb, obs_rnw, obs_addr);
    end
    @(posedge clk); #1;
    m_byte1 = 8'h99;
    d_addr_i = 16'h0041; d_we_i = 1; d_wdata_i = 8'h33; d_req_i = 1;
    #1;
    checks++;
    if (d_gnt_o !== 1'b1) begin
      failures++; $display("FAIL store_gnt: got=%b exp=1", d_gnt_o);
    end
    @(posedge clk); #1 d_req_i = 0;
    wait_valid(1'b0, 50, n);
    checks++;
    if (n < 0 || obs_rnw !== 1'b0 || obs_wdata !== 8'h33 || obs_nb !== 2'b01) begin
      failures++;
      $display("FAIL store_cmd: seen=%0d rnw=%b wdata=%h nb=%b exp 0/33/01", n, obs_rnw, obs_wdata, obs_nb);
    end
    checks++;
    if (d_rdata_o !== 8'h7E) begin
      failures++; $display("FAIL store_rdata_hold: got=%h exp=7e", d_rdata_o);
    end
    d_we_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    logic [9:0] seq;
    int ng, cyc, viol;
    seq = '0; ng = 0; cyc = 0; viol = 0;
    model_lat = 0;
    if_addr_i = 16'h0100; d_addr_i = 16'h0200; d_we_i = 0;
    if_req_i = 1; d_req_i = 1;
    #1;
    while (cyc < 300) begin
      if (if_gnt_o || d_gnt_o) begin
        seq[ng] = if_gnt_o;
        ng++;
        if (busy_o || (if_gnt_o && d_gnt_o)) viol++;
      end
      if (if_valid_o && d_valid_o) viol++;
      if (ng == 10) break;
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    if_req_i = 0; d_req_i = 0;
    for (int i = 0; i < 50; i++) begin
      if (!busy_o) break;
      if (if_valid_o && d_valid_o) viol++;
      @(posedge clk); #1;
    end
    checks++;
    if (ng !== 10 || seq !== 10'b10000_10000) begin
      failures++; $display("FAIL burst_pattern: grants=%0d seq(F=1,lsb first)=%b exp 10/1000010000", ng, seq);
    end
    checks++;
    if (viol !== 0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL burst_exclusive: violations=%0d busy=%b exp 0/0", viol, busy_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    model_en = 0;
    if_addr_i = 16'h0300; if_req_i = 1;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1) begin
      failures++; $display("FAIL tmo_gnt: got=%b exp=1", if_gnt_o);
    end
    @(posedge clk); #1 if_req_i = 0;
    n = 1;
    while (!if_valid_o && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 1025 || err_o !== 1'b1) begin
      failures++; $display("FAIL tmo_cycles: valid_at=%0d err=%b exp 1025/1", n, err_o);
    end
    checks++;
    if (if_valid_o !== 1'b1 || if_instr_o !== 15'h0000) begin
      failures++; $display("FAIL tmo_data: valid=%b instr=%h exp 1/0000", if_valid_o, if_instr_o);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      failures++; $display("FAIL tmo_idle: busy=%b err=%b exp 0/1", busy_o, err_o);
    end
    model_en = 1;
  endtask

  task automatic test_reset_mid();
    int nval;
    model_lat = 20;
    d_addr_i = 16'h0050; d_we_i = 0; d_req_i = 1;
    @(posedge clk); #1 d_req_i = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1 || u_spi.spi_busy_i !== 1'b1 || err_o !== 1'b1) begin
      failures++; $display("FAIL rst_pre: busy=%b spi_busy=%b err=%b exp 1/1/1", busy_o, u_spi.spi_busy_i, err_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt_o, if_valid_o, if_instr_o, d_gnt_o, d_valid_o, d_rdata_o, err_o, busy_o,
         u_spi.spi_start_o, u_spi.spi_address_o, u_spi.spi_data_write_o,
         u_spi.spi_read_not_write_o, u_spi.spi_num_bytes_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid_zero: rdata=%h err=%b busy=%b addr=%h nb=%b exp all 0",
               d_rdata_o, err_o, busy_o, u_spi.spi_address_o, u_spi.spi_num_bytes_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nval = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (if_valid_o || d_valid_o) nval++;
    end
    checks++;
    if (nval !== 0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rst_no_valid: valids=%0d busy=%b exp 0/0", nval, busy_o);
    end
  endtask

  task automatic test_done_vs_req();
    int n;
    model_lat = 2;
    m_byte1 = 8'h12; m_byte2 = 8'h34;
    if_addr_i = 16'h0400; if_req_i = 1;
    @(posedge clk); #1 if_req_i = 0;
    n = 0;
    while (u_spi.spi_done_i !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (u_spi.spi_done_i !== 1'b1) begin
      failures++; $display("FAIL dvr_done_seen: spi_done=%b exp=1", u_spi.spi_done_i);
    end
    d_addr_i = 16'h0060; d_we_i = 0; d_req_i = 1;
    #1;
    checks++;
    if (d_gnt_o !== 1'b0) begin
      failures++; $display("FAIL dvr_gnt_wait: d_gnt=%b exp=0", d_gnt_o);
    end
    @(posedge clk); #1;
    checks++;
    if (if_valid_o !== 1'b1 || d_gnt_o !== 1'b0 || if_instr_o !== 15'h0934) begin
      failures++;
      $display("FAIL dvr_resp: if_valid=%b d_gnt=%b instr=%h exp 1/0/0934", if_valid_o, d_gnt_o, if_instr_o);
    end
    @(posedge clk); #1;
    checks++;
    if (d_gnt_o !== 1'b1 || if_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL dvr_gnt_idle: d_gnt=%b if_valid=%b busy=%b exp 1/0/0", d_gnt_o, if_valid_o, busy_o);
    end
    @(posedge clk); #1 d_req_i = 0;
    wait_valid(1'b0, 50, n);
    checks++;
    if (n < 0 || d_rdata_o !== 8'h12) begin
      failures++; $display("FAIL dvr_load: seen=%0d rdata=%h exp 12", n, d_rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_store();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_done_vs_req();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
